axi_lite_regfile: RTL and testbench

- AXI4-Lite target (slave) that terminates a 32-bit AXI-Lite bus in a bank of NUM_REGS memory-mapped registers.
- Sits directly downstream of an AXI_LITE interface used as "in"/Slave: its ports carry exactly that interface's signals.
- Exposes register contents and per-register write strobes to surrounding control logic.
- Used as the standard configuration-register endpoint behind crossbars and converters.

---
 rtl/axi_pkg.sv | 26 ++
 rtl/axi_lite_wr_join.sv | 84 ++++++++
 rtl/axi_lite_regfile.sv | 204 ++++++++++++++++++++
 tb/tb_axi_lite_regfile.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// ============================================================================
// Module   : axi_pkg
// Brief    : Shared AXI response encoding plus a small sizing helper used by
//            AXI-Lite targets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  // Width of a register index field; never narrower than one bit so that a
  // single-register bank still has a decodable (and range-checkable) index.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : axi_pkg

`default_nettype wire

// File: rtl/axi_lite_wr_join.sv
// ============================================================================
// Module   : axi_lite_wr_join
// Brief    : Joins the AXI-Lite AW and W channels. Each channel has a
//            one-entry holding register so the two may arrive in any order;
//            a commit is issued once both are present and the B channel is
//            free.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_wr_join #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] aw_addr_i,
  input  logic                  aw_valid_i,
  output logic                  aw_ready_o,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  input  logic [STRB_WIDTH-1:0] w_strb_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic                  b_busy_i,
  output logic                  commit_o,
  output logic [ADDR_WIDTH-1:0] commit_addr_o,
  output logic [DATA_WIDTH-1:0] commit_data_o,
  output logic [STRB_WIDTH-1:0] commit_strb_o
);

  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_held_q,  w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q,  w_data_d;
  logic [STRB_WIDTH-1:0] w_strb_q,  w_strb_d;

  logic aw_hs, w_hs, aw_avail, w_avail;

  // A full holding register is the only thing that back-pressures a channel.
  assign aw_ready_o = ~aw_held_q;
  assign w_ready_o  = ~w_held_q;

  // Handshake detection, commit decision and next state of both holds.
  always_comb begin
    aw_hs    = aw_valid_i & ~aw_held_q;
    w_hs     = w_valid_i  & ~w_held_q;
    aw_avail = aw_held_q | aw_hs;
    w_avail  = w_held_q  | w_hs;

    // A pending response blocks the commit; the halves stay parked.
    commit_o = aw_avail & w_avail & ~b_busy_i;

    commit_addr_o = aw_held_q ? aw_addr_q : aw_addr_i;
    commit_data_o = w_held_q  ? w_data_q  : w_data_i;
    commit_strb_o = w_held_q  ? w_strb_q  : w_strb_i;

    aw_held_d = aw_avail & ~commit_o;
    w_held_d  = w_avail  & ~commit_o;
    aw_addr_d = aw_hs ? aw_addr_i : aw_addr_q;
    w_data_d  = w_hs  ? w_data_i  : w_data_q;
    w_strb_d  = w_hs  ? w_strb_i  : w_strb_q;
  end

  // Holding-register state; reset discards any half-received write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
    end
  end

endmodule : axi_lite_wr_join

`default_nettype wire

// File: rtl/axi_lite_regfile.sv
// ============================================================================
// Module   : axi_lite_regfile
// Brief    : AXI4-Lite target terminating the bus in NUM_REGS memory-mapped
//            registers, with optional read-only registers sourced from
//            ro_data_i, exposed register contents and per-register write
//            pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_regfile
  import axi_pkg::*;
#(
  parameter int unsigned                       ADDR_WIDTH = 32,
  parameter int unsigned                       DATA_WIDTH = 32,
  parameter int unsigned                       NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]               RO_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]    RESET_VAL  = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [ADDR_WIDTH-1:0]          aw_addr_i,
  input  logic                           aw_valid_i,
  output logic                           aw_ready_o,
  input  logic [DATA_WIDTH-1:0]          w_data_i,
  input  logic [DATA_WIDTH/8-1:0]        w_strb_i,
  input  logic                           w_valid_i,
  output logic                           w_ready_o,
  output logic [1:0]                     b_resp_o,
  output logic                           b_valid_o,
  input  logic                           b_ready_i,
  input  logic [ADDR_WIDTH-1:0]          ar_addr_i,
  input  logic                           ar_valid_i,
  output logic                           ar_ready_o,
  output logic [DATA_WIDTH-1:0]          r_data_o,
  output logic [1:0]                     r_resp_o,
  output logic                           r_valid_o,
  input  logic                           r_ready_i,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_data_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFF_W      = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W      = idx_bits(NUM_REGS);

  // Write join outputs
  logic                  commit;
  logic [ADDR_WIDTH-1:0] commit_addr;
  logic [DATA_WIDTH-1:0] commit_data;
  logic [STRB_WIDTH-1:0] commit_strb;

  // Register bank and write response
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic                  b_valid_q, b_valid_d;
  resp_t                 b_resp_q,  b_resp_d;
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_hit, wr_ro, wr_ok;

  // Read channel
  logic                  r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_data_q,  r_data_d;
  resp_t                 r_resp_q,  r_resp_d;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] rd_val;

  // Only the index field of each address is decoded; the rest is don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{commit_addr, ar_addr_i};

  axi_lite_wr_join #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH)
  ) u_wr_join (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .aw_addr_i     (aw_addr_i),
    .aw_valid_i    (aw_valid_i),
    .aw_ready_o    (aw_ready_o),
    .w_data_i      (w_data_i),
    .w_strb_i      (w_strb_i),
    .w_valid_i     (w_valid_i),
    .w_ready_o     (w_ready_o),
    .b_busy_i      (b_valid_q),
    .commit_o      (commit),
    .commit_addr_o (commit_addr),
    .commit_data_o (commit_data),
    .commit_strb_o (commit_strb)
  );

  assign wr_idx = commit_addr[OFF_W +: IDX_W];
  assign rd_idx = ar_addr_i[OFF_W +: IDX_W];

  // Write decode, byte-enabled register update, pulse and B response.
  // With a power-of-two NUM_REGS every index is in range; otherwise the
  // upper indices miss every register and answer SLVERR.
  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    wr_hit     = 1'b0;
    wr_ro      = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == IDX_W'(i)) begin
        wr_hit = 1'b1;
        wr_ro  = RO_MASK[i];
      end
    end
    wr_ok = wr_hit & ~wr_ro;

    if (commit && wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          // The pulse fires even for an all-zero strobe.
          wr_pulse_d[i] = 1'b1;
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (commit_strb[b]) begin
              regs_d[i][8*b +: 8] = commit_data[8*b +: 8];
            end
          end
        end
      end
    end

    b_valid_d = b_valid_q;
    b_resp_d  = b_resp_q;
    if (b_valid_q && b_ready_i) begin
      b_valid_d = 1'b0;
    end
    if (commit) begin
      b_valid_d = 1'b1;
      b_resp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read decode and R channel; reads see the bank before this cycle's write.
  always_comb begin
    rd_hit = 1'b0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_hit = 1'b1;
        rd_val = RO_MASK[i] ? ro_data_i[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      end
    end

    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    if (r_valid_q && r_ready_i) begin
      r_valid_d = 1'b0;
    end
    // AR is only accepted while no response is outstanding (no bypass).
    if (ar_valid_i && !r_valid_q) begin
      r_valid_d = 1'b1;
      r_data_d  = rd_hit ? rd_val : '0;
      r_resp_d  = rd_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Register bank, pulses and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
      end
      wr_pulse_q <= '0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
    end
  end

  assign ar_ready_o = ~r_valid_q;
  assign b_valid_o  = b_valid_q;
  assign b_resp_o   = b_resp_q;
  assign r_valid_o  = r_valid_q;
  assign r_data_o   = r_data_q;
  assign r_resp_o   = r_resp_q;
  assign wr_pulse_o = wr_pulse_q;

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
      assign reg_q_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  endgenerate

endmodule : axi_lite_regfile

`default_nettype wire

// File: tb/tb_axi_lite_regfile.sv
// ============================================================================
// Module   : tb_axi_lite_regfile
// Brief    : Self-checking bench for axi_lite_regfile: directed scenarios
//            with literal expectations, then randomized traffic checked
//            every cycle against a behavioural model of the register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_lite_regfile;

  localparam int NR = 12;
  localparam int DW = 32;
  localparam logic [NR-1:0]    ROM = 12'h088;
  localparam logic [NR*DW-1:0] RV  = {{6{32'h0}}, 32'hA5A5_0005, {5{32'h0}}};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [31:0]     aw_addr = '0;
  logic            aw_valid = 1'b0;
  logic            aw_ready;
  logic [31:0]     w_data = '0;
  logic [3:0]      w_strb = '0;
  logic            w_valid = 1'b0;
  logic            w_ready;
  logic [1:0]      b_resp;
  logic            b_valid;
  logic            b_ready = 1'b1;
  logic [31:0]     ar_addr = '0;
  logic            ar_valid = 1'b0;
  logic            ar_ready;
  logic [31:0]     r_data;
  logic [1:0]      r_resp;
  logic            r_valid;
  logic            r_ready = 1'b1;
  logic [NR*DW-1:0] ro_data = '0;
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0]   wr_pulse;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  axi_lite_regfile #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .RO_MASK    (ROM),
    .RESET_VAL  (RV)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .aw_addr_i  (aw_addr),
    .aw_valid_i (aw_valid),
    .aw_ready_o (aw_ready),
    .w_data_i   (w_data),
    .w_strb_i   (w_strb),
    .w_valid_i  (w_valid),
    .w_ready_o  (w_ready),
    .b_resp_o   (b_resp),
    .b_valid_o  (b_valid),
    .b_ready_i  (b_ready),
    .ar_addr_i  (ar_addr),
    .ar_valid_i (ar_valid),
    .ar_ready_o (ar_ready),
    .r_data_o   (r_data),
    .r_resp_o   (r_resp),
    .r_valid_o  (r_valid),
    .r_ready_i  (r_ready),
    .ro_data_i  (ro_data),
    .reg_q_o    (reg_q),
    .wr_pulse_o (wr_pulse)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]   m_reg [NR];
  bit            m_aw_h, m_w_h, m_b_v, m_r_v;
  logic [31:0]   m_aw_a, m_w_d, m_r_d;
  logic [3:0]    m_w_s;
  logic [1:0]    m_b_r, m_r_r;
  logic [NR-1:0] m_pulse;
  bit            m_awhs, m_whs, m_arhs;

  function automatic int reg_index(input logic [31:0] a);
    return int'((a >> 2) % 16);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) m_reg[i] = RV[i*DW +: DW];
      m_aw_h = 0; m_w_h = 0; m_b_v = 0; m_r_v = 0;
      m_aw_a = '0; m_w_d = '0; m_w_s = '0;
      m_r_d = '0; m_r_r = 2'd0; m_b_r = 2'd0; m_pulse = '0;
      m_awhs = 0; m_whs = 0; m_arhs = 0;
    end else begin
      bit awhs, whs, arhs, commit;
      logic [31:0] ca, cd;
      logic [3:0]  cs;
      int idx;
      awhs = aw_valid && !m_aw_h;
      whs  = w_valid && !m_w_h;
      arhs = ar_valid && !m_r_v;
      // read channel, observing registers before any write of this cycle
      if (m_r_v && r_ready) m_r_v = 0;
      if (arhs) begin
        idx = reg_index(ar_addr);
        m_r_v = 1;
        if (idx >= NR) begin
          m_r_d = 32'h0; m_r_r = 2'd2;
        end else if (ROM[idx]) begin
          m_r_d = ro_data[idx*DW +: DW]; m_r_r = 2'd0;
        end else begin
          m_r_d = m_reg[idx]; m_r_r = 2'd0;
        end
      end
      // write channel
      commit = (m_aw_h || awhs) && (m_w_h || whs) && !m_b_v;
      ca = m_aw_h ? m_aw_a : aw_addr;
      cd = m_w_h ? m_w_d : w_data;
      cs = m_w_h ? m_w_s : w_strb;
      if (awhs) begin m_aw_h = 1; m_aw_a = aw_addr; end
      if (whs)  begin m_w_h = 1;  m_w_d = w_data; m_w_s = w_strb; end
      if (m_b_v && b_ready) m_b_v = 0;
      m_pulse = '0;
      if (commit) begin
        m_aw_h = 0; m_w_h = 0; m_b_v = 1;
        idx = reg_index(ca);
        if (idx >= NR || ROM[idx]) begin
          m_b_r = 2'd2;
        end else begin
          m_b_r = 2'd0;
          m_pulse[idx] = 1'b1;
          for (int b = 0; b < 4; b++)
            if (cs[b]) m_reg[idx][8*b +: 8] = cd[8*b +: 8];
        end
      end
      m_awhs = awhs; m_whs = whs; m_arhs = arhs;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en && rst_n) begin
      chk("aw_ready", aw_ready, !m_aw_h);
      chk("w_ready",  w_ready,  !m_w_h);
      chk("ar_ready", ar_ready, !m_r_v);
      chk("b_valid",  b_valid,  m_b_v);
      chk("r_valid",  r_valid,  m_r_v);
      chk("wr_pulse", wr_pulse, m_pulse);
      if (m_b_v) chk("b_resp", b_resp, m_b_r);
      if (m_r_v) begin
        chk("r_data", r_data, m_r_d);
        chk("r_resp", r_resp, m_r_r);
      end
      for (int i = 0; i < NR; i++)
        chk($sformatf("reg_q[%0d]", i), reg_q[i*DW +: DW], m_reg[i]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    aw_valid = 1; aw_addr = a; w_valid = 1; w_data = d; w_strb = s;
    @(negedge clk);
    aw_valid = 0; w_valid = 0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    ar_valid = 1; ar_addr = a;
    @(negedge clk);
    ar_valid = 0;
  endtask

  task automatic random_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      if (!aw_valid || m_awhs) begin
        aw_valid = ($urandom % 3) == 0;
        aw_addr  = $urandom;
      end
      if (!w_valid || m_whs) begin
        w_valid = ($urandom % 3) == 0;
        w_data  = $urandom;
        w_strb  = 4'($urandom);
      end
      if (!ar_valid || m_arhs) begin
        ar_valid = ($urandom % 3) == 0;
        ar_addr  = $urandom;
      end
      b_ready = ($urandom % 4) != 0;
      r_ready = ($urandom % 4) != 0;
      if (($urandom % 8) == 0) ro_data[($urandom % NR)*DW +: DW] = $urandom;
      @(negedge clk);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    // reset state
    chk("rst aw_ready", aw_ready, 1);
    chk("rst w_ready",  w_ready,  1);
    chk("rst ar_ready", ar_ready, 1);
    chk("rst b_valid",  b_valid,  0);
    chk("rst r_valid",  r_valid,  0);
    chk("rst wr_pulse", wr_pulse, 0);
    chk("rst b_resp",   b_resp,   0);
    chk("rst r_data",   r_data,   0);
    chk("rst reg5",     reg_q[5*DW +: DW], 32'hA5A5_0005);
    chk("rst reg2",     reg_q[2*DW +: DW], 32'h0);
    rst_n = 1;
    check_en = 1;

    // AW+W same cycle
    send_aw_w(32'h8, 32'hDEADBEEF, 4'hF);
    chk("t1 b_valid", b_valid, 1);
    chk("t1 b_resp",  b_resp, 0);
    chk("t1 reg2",    reg_q[2*DW +: DW], 32'hDEADBEEF);
    chk("t1 pulse",   wr_pulse, 12'h004);
    @(negedge clk);
    chk("t1 pulse off", wr_pulse, 0);
    chk("t1 b drained", b_valid, 0);

    // W first, AW three cycles later
    w_valid = 1; w_data = 32'h1234ABCD; w_strb = 4'h3;
    @(negedge clk);
    w_valid = 0;
    chk("t2 w_ready held", w_ready, 0);
    chk("t2 aw_ready", aw_ready, 1);
    repeat (2) @(negedge clk);
    chk("t2 w_ready still", w_ready, 0);
    aw_valid = 1; aw_addr = 32'h4;
    @(negedge clk);
    aw_valid = 0;
    chk("t2 b_valid", b_valid, 1);
    chk("t2 reg1", reg_q[1*DW +: DW], 32'h0000ABCD);
    chk("t2 w_ready free", w_ready, 1);
    chk("t2 pulse", wr_pulse, 12'h002);
    @(negedge clk);

    // out-of-range index (12) and aliasing of upper address bits
    send_aw_w(32'h30, 32'hFFFFFFFF, 4'hF);
    chk("t3 oor resp", b_resp, 2);
    chk("t3 oor pulse", wr_pulse, 0);
    @(negedge clk);
    send_aw_w(32'h40, 32'h11, 4'hF);
    chk("t3 alias resp", b_resp, 0);
    chk("t3 alias reg0", reg_q[0 +: DW], 32'h11);
    @(negedge clk);
    send_ar(32'h30);
    chk("t3 rd valid", r_valid, 1);
    chk("t3 rd data", r_data, 0);
    chk("t3 rd resp", r_resp, 2);
    @(negedge clk);

    // read-only register 3
    ro_data[3*DW +: DW] = 32'hCAFE0000;
    send_aw_w(32'hC, 32'h1, 4'hF);
    chk("t4 ro wr resp", b_resp, 2);
    chk("t4 ro pulse", wr_pulse, 0);
    @(negedge clk);
    send_ar(32'hC);
    chk("t4 ro rd data", r_data, 32'hCAFE0000);
    chk("t4 ro rd resp", r_resp, 0);
    @(negedge clk);

    // all-zero strobe
    send_aw_w(32'h8, 32'hFFFFFFFF, 4'h0);
    chk("t4 zs resp", b_resp, 0);
    chk("t4 zs reg2", reg_q[2*DW +: DW], 32'hDEADBEEF);
    chk("t4 zs pulse", wr_pulse, 12'h004);
    @(negedge clk);

    // back-pressure on B and R
    b_ready = 0; r_ready = 0;
    send_aw_w(32'h14, 32'h55, 4'h1);
    chk("t5 reg5", reg_q[5*DW +: DW], 32'hA5A5_0055);
    send_ar(32'h8);
    send_aw_w(32'h18, 32'h66, 4'hF);
    for (int k = 0; k < 5; k++) begin
      chk("t5 b hold", b_valid, 1);
      chk("t5 b resp", b_resp, 0);
      chk("t5 r hold", r_valid, 1);
      chk("t5 r data", r_data, 32'hDEADBEEF);
      chk("t5 aw_ready", aw_ready, 0);
      chk("t5 w_ready", w_ready, 0);
      chk("t5 ar_ready", ar_ready, 0);
      @(negedge clk);
    end
    b_ready = 1;
    @(negedge clk);
    chk("t5 b drained", b_valid, 0);
    chk("t5 aw still held", aw_ready, 0);
    @(negedge clk);
    chk("t5 b second", b_valid, 1);
    chk("t5 reg6", reg_q[6*DW +: DW], 32'h66);
    chk("t5 aw free", aw_ready, 1);
    r_ready = 1;
    @(negedge clk);
    chk("t5 r drained", r_valid, 0);
    chk("t5 ar free", ar_ready, 1);
    @(negedge clk);

    // same-cycle read and write of register 0
    aw_valid = 1; aw_addr = 32'h0; w_valid = 1; w_data = 32'h22; w_strb = 4'hF;
    ar_valid = 1; ar_addr = 32'h0;
    @(negedge clk);
    aw_valid = 0; w_valid = 0; ar_valid = 0;
    chk("t6 rd old", r_data, 32'h11);
    chk("t6 reg0 new", reg_q[0 +: DW], 32'h22);
    @(negedge clk);
    send_ar(32'h0);
    chk("t6 rd new", r_data, 32'h22);
    @(negedge clk);

    // randomized traffic
    random_cycles(3000);

    // asynchronous reset in the middle of traffic
    #2 rst_n = 0;
    aw_valid = 0; w_valid = 0; ar_valid = 0;
    @(negedge clk);
    chk("mid rst aw_ready", aw_ready, 1);
    chk("mid rst w_ready",  w_ready,  1);
    chk("mid rst b_valid",  b_valid,  0);
    chk("mid rst r_valid",  r_valid,  0);
    chk("mid rst pulse",    wr_pulse, 0);
    chk("mid rst reg5",     reg_q[5*DW +: DW], 32'hA5A5_0005);
    chk("mid rst reg2",     reg_q[2*DW +: DW], 32'h0);
    rst_n = 1;
    @(negedge clk);
    random_cycles(2000);

    aw_valid = 0; w_valid = 0; ar_valid = 0; b_ready = 1; r_ready = 1;
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_axi_lite_regfile

`default_nettype wire
